// File: rtl/mux16_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
package mux16_pkg;

  localparam int unsigned DEF_WIDTH     = 16;
  localparam int unsigned DEF_MAX_BURST = 4;

  // Arbitration states; sel is derived directly from GRANT1.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_e;

  // Owner encodings, matching the mux select value.
  localparam logic OWN0 = 1'b0;
  localparam logic OWN1 = 1'b1;

endpackage

// File: rtl/mux16_out_slice.sv
// One-entry valid/ready output register: loads on a beat, drains on out_ready,
// and supports drain+load in the same cycle for one word per cycle.
module mux16_out_slice
  import mux16_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             out_ready_i,
  output logic             can_load_o,
  output logic             out_valid_o,
  output logic [WIDTH-1:0] out_data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;

  // A slot is free when empty or when the held word leaves this cycle.
  assign can_load_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;

  // Next buffer contents: a load wins over a drain; data holds otherwise.
  always_comb begin
    valid_d = load_i || (valid_q && !out_ready_i);
    data_d  = load_i ? data_i : data_q;
  end

  // Buffer registers.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent races.
  // NOTE: the data word is reset as well because out_data must read 0 after
  // reset; a plain datapath register would normally be left unreset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/mux16_rr_arbiter.sv
// Round-robin arbiter with burst cap sharing a WIDTH-bit 2:1 mux between two
// streaming requesters; the selected word lands in a one-entry output buffer.
module mux16_rr_arbiter
  import mux16_pkg::*;
#(
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned MAX_BURST = DEF_MAX_BURST
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0_valid,
  input  logic [WIDTH-1:0] in0_data,
  output logic             in0_ready,
  input  logic             in1_valid,
  input  logic [WIDTH-1:0] in1_data,
  output logic             in1_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             sel
);

  localparam int unsigned     CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  state_e           state_q, state_d;
  logic             last_owner_q, last_owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d, cnt_after;
  logic             can_load, beat0, beat1, beat, cap_hit;
  logic [WIDTH-1:0] mux_data;

  // Select follows the registered state, so the grant is glitch-free.
  assign sel       = (state_q == GRANT1);
  assign mux_data  = sel ? in1_data : in0_data;
  assign in0_ready = (state_q == GRANT0) && can_load;
  assign in1_ready = (state_q == GRANT1) && can_load;
  assign beat0     = in0_valid && in0_ready;
  assign beat1     = in1_valid && in1_ready;
  assign beat      = beat0 || beat1;

  // Burst count including this cycle's beat, saturating at the cap.
  always_comb begin
    cnt_after = burst_cnt_q;
    if (beat && (burst_cnt_q != CNT_MAX)) begin
      cnt_after = burst_cnt_q + 1'b1;
    end
    cap_hit = (cnt_after == CNT_MAX);
  end

  // Next-state, burst counter and last-owner logic.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d      = state_q;
    burst_cnt_d  = burst_cnt_q;
    last_owner_d = last_owner_q;
    unique case (state_q)
      IDLE: begin
        if (in0_valid && in1_valid) begin
          state_d = (last_owner_q == OWN1) ? GRANT0 : GRANT1;
        end else if (in0_valid) begin
          state_d = GRANT0;
        end else if (in1_valid) begin
          state_d = GRANT1;
        end
      end
      GRANT0: begin
        if (beat0) last_owner_d = OWN0;
        if (in1_valid && (!in0_valid || cap_hit)) begin
          state_d     = GRANT1;
          burst_cnt_d = '0;
        end else if (!in0_valid && !in1_valid) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = cnt_after;
        end
      end
      GRANT1: begin
        if (beat1) last_owner_d = OWN1;
        if (in0_valid && (!in1_valid || cap_hit)) begin
          state_d     = GRANT0;
          burst_cnt_d = '0;
        end else if (!in0_valid && !in1_valid) begin
          state_d     = IDLE;
          burst_cnt_d = '0;
        end else begin
          burst_cnt_d = cnt_after;
        end
      end
      default: begin
        state_d     = IDLE;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_owner_q <= OWN1;
      burst_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  mux16_out_slice #(
    .WIDTH(WIDTH)
  ) u_out_slice (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (beat),
    .data_i     (mux_data),
    .out_ready_i(out_ready),
    .can_load_o (can_load),
    .out_valid_o(out_valid),
    .out_data_o (out_data)
  );

endmodule

// File: tb/tb_mux16_rr_arbiter.sv
// Self-checking bench for mux16_rr_arbiter: directed scenarios plus a random
// phase, all compared against a transaction-level model of owner, burst run
// and an output word queue.
module tb_mux16_rr_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in0_valid = 1'b0, in1_valid = 1'b0, out_ready = 1'b0;
  logic [15:0] in0_data = '0, in1_data = '0;
  logic        in0_ready, in1_ready, out_valid, sel;
  logic [15:0] out_data;

  int checks = 0;
  int failures = 0;

  // Model: owner (-1 = nobody), last owner, beats in current grant, buffer.
  int          m_owner, m_last, m_run;
  logic [15:0] m_buf[$];
  logic [15:0] got[$];
  int          beats0, beats1;

  always #5 clk = ~clk;

  mux16_rr_arbiter #(.WIDTH(16), .MAX_BURST(MAX_BURST)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in0_valid(in0_valid),
    .in0_data (in0_data),
    .in0_ready(in0_ready),
    .in1_valid(in1_valid),
    .in1_data (in1_data),
    .in1_ready(in1_ready),
    .out_valid(out_valid),
    .out_data (out_data),
    .out_ready(out_ready),
    .sel      (sel)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_last  = 1;
    m_run   = 0;
    m_buf.delete();
    got.delete();
    beats0 = 0;
    beats1 = 0;
  endtask

  // Asynchronous reset pulse: outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 16'h0000);
    check("rst_in0_ready", in0_ready, 1'b0);
    check("rst_in1_ready", in1_ready, 1'b0);
    check("rst_sel", sel, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock cycle: compare at negedge, advance model, then advance sources.
  task automatic step();
    bit r0, r1, b0, b1, bt, cur_v, oth_v;
    int run_after;
    @(negedge clk);
    r0 = (m_owner == 0) && (m_buf.size() == 0 || out_ready);
    r1 = (m_owner == 1) && (m_buf.size() == 0 || out_ready);
    check("in0_ready", in0_ready, r0);
    check("in1_ready", in1_ready, r1);
    check("sel", sel, m_owner == 1);
    check("out_valid", out_valid, m_buf.size() != 0);
    if (m_buf.size() != 0) check("out_data", out_data, m_buf[0]);
    b0 = in0_valid && r0;
    b1 = in1_valid && r1;
    if (m_buf.size() != 0 && out_ready) got.push_back(m_buf.pop_front());
    if (b0) m_buf.push_back(in0_data);
    if (b1) m_buf.push_back(in1_data);
    if (m_owner < 0) begin
      if (in0_valid && in1_valid) m_owner = 1 - m_last;
      else if (in0_valid)         m_owner = 0;
      else if (in1_valid)         m_owner = 1;
    end else begin
      cur_v = (m_owner == 0) ? in0_valid : in1_valid;
      oth_v = (m_owner == 0) ? in1_valid : in0_valid;
      bt    = b0 || b1;
      if (bt) m_last = m_owner;
      run_after = m_run + (bt ? 1 : 0);
      if (run_after > MAX_BURST) run_after = MAX_BURST;
      if (oth_v && (!cur_v || run_after >= MAX_BURST)) begin
        m_owner = 1 - m_owner;
        m_run   = 0;
      end else if (!cur_v && !oth_v) begin
        m_owner = -1;
        m_run   = 0;
      end else begin
        m_run = run_after;
      end
    end
    @(posedge clk);
    #1;
    if (b0) begin beats0++; in0_data = in0_data + 16'd1; end
    if (b1) begin beats1++; in1_data = in1_data + 16'd1; end
  endtask

  initial begin
    int n1;
    model_reset();
    #2;
    // Power-on reset state.
    check("por_out_valid", out_valid, 1'b0);
    check("por_sel", sel, 1'b0);
    do_reset();

    // Single requester: 0x0001..0x0008, 2-cycle fill, one word per cycle.
    in0_data = 16'h0001; in0_valid = 1'b1; out_ready = 1'b1;
    step();
    check("lat_no_out_n1", out_valid, 1'b0);
    step();
    check("lat_out_n2", out_valid, 1'b1);
    check("lat_data_n2", out_data, 16'h0001);
    for (int c = 0; c < 40 && beats0 < 8; c++) step();
    in0_valid = 1'b0;
    for (int c = 0; c < 4; c++) step();
    check("single_count", 16'(got.size()), 16'd8);
    if (got.size() == 8)
      for (int k = 0; k < 8; k++) check("single_order", got[k], 16'(k + 1));

    // Contention: groups of MAX_BURST words alternating, in0 first on a tie.
    do_reset();
    in0_data = 16'hA000; in1_data = 16'hB000;
    in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 60 && got.size() < 16; c++) step();
    check("cont_count", 16'(got.size() >= 16), 16'd1);
    if (got.size() >= 16)
      for (int k = 0; k < 16; k++)
        check("cont_pattern", got[k],
              (((k / 4) % 2 == 0) ? 16'hA000 : 16'hB000) + 16'(((k / 8) * 4) + (k % 4)));

    // Reset mid-stream with a buffered word; tie after release goes to in0.
    check("mid_out_valid_before", out_valid, 1'b1);
    do_reset();
    step();
    step();
    check("mid_tie_sel", sel, 1'b0);
    for (int c = 0; c < 6; c++) step();

    // Backpressure: 0xBEEF held for 5 stalled cycles, nothing lost.
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    do_reset();
    in0_data = 16'hBEEF; in0_valid = 1'b1;
    step();
    step();
    for (int c = 0; c < 5; c++) begin
      step();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_data", out_data, 16'hBEEF);
    end
    out_ready = 1'b1;
    step();
    in0_valid = 1'b0;
    for (int c = 0; c < 3; c++) step();
    check("bp_count", 16'(got.size()), 16'd2);
    if (got.size() == 2) begin
      check("bp_word0", got[0], 16'hBEEF);
      check("bp_word1", got[1], 16'hBEF0);
    end

    // Early release: in0 drops after 2 beats, ownership moves at once.
    do_reset();
    in0_data = 16'hC000; in1_data = 16'hD000;
    in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 10 && beats0 < 2; c++) step();
    in0_valid = 1'b0;
    step();
    check("early_sel", sel, 1'b1);
    in0_valid = 1'b1;
    n1 = beats1;
    for (int c = 0; c < 12 && sel; c++) step();
    check("early_in1_burst", 16'(beats1 - n1), 16'(MAX_BURST));

    // Both idle from GRANT1: IDLE next cycle, output drains.
    in0_valid = 1'b0;
    for (int c = 0; c < 6; c++) step();
    check("idle_g1_sel", sel, 1'b1);
    in1_valid = 1'b0;
    step();
    check("idle_sel", sel, 1'b0);
    step();
    check("idle_drained", out_valid, 1'b0);

    // Random traffic against the model.
    for (int c = 0; c < 600; c++) begin
      in0_valid = ($urandom_range(0, 3) != 0);
      in1_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    check("final_empty", out_valid, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
